// File: rtl/mpu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mpu_op_sequencer
// Description : Element-wise operation sequencer for DIM x DIM matrices.
//               It accepts one command (opcode and two operand matrices) and
//               computes one result row per cycle through a shared DIM-lane
//               ALU. Supported operations are add, sub, negate and transpose.
//               The finished matrix is presented through a valid/ready
//               handshake.
// Options     : `define MPU_SAT_EN makes add, sub and negate saturate to the
//               signed element range. When it is undefined, they wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module mpu_op_sequencer #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 opcode,
  input  logic [ELEM_W*DIM*DIM-1:0]  matrix_a,
  input  logic [ELEM_W*DIM*DIM-1:0]  matrix_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ELEM_W*DIM*DIM-1:0]  result,
  output logic                       overflow,
  output logic                       busy
);

  localparam int MAT_W = ELEM_W * DIM * DIM;
  localparam int ROW_W = $clog2(DIM);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NEG = 2'b10;

  localparam logic [ELEM_W-1:0] ELEM_MIN  = {1'b1, {(ELEM_W-1){1'b0}}};
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [1:0]         op_q, op_d;
  logic [MAT_W-1:0]   a_q, a_d;
  logic [MAT_W-1:0]   b_q, b_d;
  logic [MAT_W-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;

  logic [ELEM_W-1:0]  lane_res [DIM];
  logic [DIM-1:0]     lane_ovf;

  // Per-lane ALU: lane j operates on element (row_q, j). Lanes are independent.
  always_comb begin
    int                idx_rc;
    int                idx_cr;
    logic [ELEM_W-1:0] ea;
    logic [ELEM_W-1:0] eb;
    logic [ELEM_W-1:0] et;
    logic [ELEM_W-1:0] wr;
    logic              ov;
    for (int j = 0; j < DIM; j++) begin
      idx_rc = ELEM_W * (int'(row_q) + DIM * j);
      idx_cr = ELEM_W * (j + DIM * int'(row_q));
      ea = a_q[idx_rc +: ELEM_W];
      eb = b_q[idx_rc +: ELEM_W];
      et = a_q[idx_cr +: ELEM_W];
      wr = '0;
      ov = 1'b0;
      case (op_q)
        OP_ADD: begin
          wr = ea + eb;
          ov = (ea[ELEM_W-1] == eb[ELEM_W-1]) && (wr[ELEM_W-1] != ea[ELEM_W-1]);
        end
        OP_SUB: begin
          wr = ea - eb;
          ov = (ea[ELEM_W-1] != eb[ELEM_W-1]) && (wr[ELEM_W-1] != ea[ELEM_W-1]);
        end
        OP_NEG: begin
          wr = '0 - ea;
          ov = (ea == ELEM_MIN);
        end
        default: begin
          // Transpose: result(r,j) = a(j,r), which is pure data movement.
          wr = et;
          ov = 1'b0;
        end
      endcase
`ifdef MPU_SAT_EN
      // Negate can only overflow toward +max. Add and sub clamp toward
      // the sign of operand a, because the true result shares that sign.
      if (ov) begin
        wr = ((op_q == OP_NEG) || !ea[ELEM_W-1]) ? ~ELEM_MIN : ELEM_MIN;
      end
`endif
      lane_res[j] = wr;
      lane_ovf[j] = ov;
    end
  end

  // Next-state logic, the row writeback path and the handshake outputs.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    cmd_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = opcode;
          a_d     = matrix_a;
          b_d     = matrix_b;
          ovf_d   = 1'b0;
          row_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int j = 0; j < DIM; j++) begin
          result_d[ELEM_W * (int'(row_q) + DIM * j) +: ELEM_W] = lane_res[j];
        end
        ovf_d = ovf_q | (|lane_ovf);
        if (row_q == LAST_ROW) begin
          state_d = S_DONE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_DONE: begin
        // Consuming the result frees the sequencer in the same cycle, so a
        // new command can be accepted here without an idle cycle.
        cmd_ready = res_ready;
        if (res_ready) begin
          if (cmd_valid) begin
            op_d    = opcode;
            a_d     = matrix_a;
            b_d     = matrix_b;
            ovf_d   = 1'b0;
            row_d   = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result    = result_q;
  assign overflow  = ovf_q;
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_mpu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpu_op_sequencer
// Description : Directed self-checking bench for mpu_op_sequencer.
//               Build with MPU_SAT_EN defined to match a saturating DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpu_op_sequencer;

  localparam int MAT_W = 200;

  logic             clock;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       opcode;
  logic [MAT_W-1:0] matrix_a;
  logic [MAT_W-1:0] matrix_b;
  logic             res_valid;
  logic             res_ready;
  logic [MAT_W-1:0] result;
  logic             overflow;
  logic             busy;

  int n_cmp;
  int n_err;

  mpu_op_sequencer #(.ELEM_W(8), .DIM(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .opcode    (opcode),
    .matrix_a  (matrix_a),
    .matrix_b  (matrix_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [MAT_W-1:0] fill(input logic [7:0] v);
    logic [MAT_W-1:0] m;
    for (int k = 0; k < 25; k++) m[8*k +: 8] = v;
    return m;
  endfunction

  // a(i,j) = 5*i+j when want_t=0, or its transpose 5*j+i when want_t=1.
  function automatic logic [MAT_W-1:0] index_pattern(input bit want_t);
    logic [MAT_W-1:0] m;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        m[8*(i+5*j) +: 8] = want_t ? 8'(5*j+i) : 8'(5*i+j);
    return m;
  endfunction

  // Offer a command at a falling edge. The caller moves past the accepting edge.
  task automatic offer(input logic [1:0] op, input logic [MAT_W-1:0] a,
                       input logic [MAT_W-1:0] b);
    cmd_valid = 1'b1;
    opcode    = op;
    matrix_a  = a;
    matrix_b  = b;
  endtask

  // Wait (bounded) for res_valid. The task returns at a falling edge.
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 ||
        overflow !== 1'b0 || result !== '0) begin
      n_err++;
      $display("FAIL reset_idle: rdy=%b vld=%b busy=%b ovf=%b res=%h, required rdy=1 vld=0 busy=0 ovf=0 res=0",
               cmd_ready, res_valid, busy, overflow, result);
    end
  endtask

  task automatic test_sub();
    bit ok;
    @(negedge clock);
    offer(2'b01, fill(8'd1), fill(8'd25));
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      n_cmp++;
      if (busy !== 1'b1 || res_valid !== 1'b0) begin
        n_err++;
        $display("FAIL sub_run_cycle%0d: busy=%b vld=%b, required busy=1 vld=0", k, busy, res_valid);
      end
    end
    @(negedge clock);
    n_cmp++;
    if (res_valid !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL sub_latency: vld=%b busy=%b at 5 edges after accept, required vld=1 busy=0", res_valid, busy);
      wait_done(ok);
    end
    n_cmp++;
    if (result !== fill(8'd232) || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL sub_result: res=%h ovf=%b, required res=%h ovf=0", result, overflow, fill(8'd232));
    end
    release_result();
    n_cmp++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL sub_release: vld=%b rdy=%b, required vld=0 rdy=1", res_valid, cmd_ready);
    end
  endtask

  task automatic test_add();
    bit ok;
    logic [MAT_W-1:0] exp_res;
`ifdef MPU_SAT_EN
    exp_res = fill(8'd127);
`else
    exp_res = fill(8'd200);
`endif
    offer(2'b00, fill(8'd100), fill(8'd100));
    @(posedge clock);
    @(negedge clock);
    // Operand changes after the accept must not affect the result.
    cmd_valid = 1'b0;
    matrix_a  = fill(8'd7);
    matrix_b  = fill(8'd9);
    opcode    = 2'b11;
    wait_done(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL add_timeout: res_valid=%b, required 1 within 20 cycles", res_valid);
    end
    n_cmp++;
    if (result !== exp_res || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL add_result: res=%h ovf=%b, required res=%h ovf=1", result, overflow, exp_res);
    end
    release_result();
  endtask

  task automatic test_transpose();
    bit ok;
    offer(2'b11, index_pattern(1'b0), fill(8'hFF));
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    wait_done(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL tr_timeout: res_valid=%b, required 1 within 20 cycles", res_valid);
    end
    n_cmp++;
    if (result !== index_pattern(1'b1) || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL tr_result: res=%h ovf=%b, required res=%h ovf=0", result, overflow, index_pattern(1'b1));
    end
    n_cmp++;
    if (result[8*(0+5*1) +: 8] !== 8'd5 || result[8*(1+5*0) +: 8] !== 8'd1) begin
      n_err++;
      $display("FAIL tr_corner: e01=%0d e10=%0d, required e01=5 e10=1",
               result[8*(0+5*1) +: 8], result[8*(1+5*0) +: 8]);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [MAT_W-1:0] exp_neg;
`ifdef MPU_SAT_EN
    exp_neg = fill(8'h7F);
`else
    exp_neg = fill(8'h80);
`endif
    offer(2'b10, fill(8'h80), fill(8'h11));
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    wait_done(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL neg_timeout: res_valid=%b, required 1 within 20 cycles", res_valid);
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clock);
      n_cmp++;
      if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || result !== exp_neg || overflow !== 1'b1) begin
        n_err++;
        $display("FAIL hold_cycle%0d: vld=%b rdy=%b ovf=%b res=%h, required vld=1 rdy=0 ovf=1 res=%h",
                 k, res_valid, cmd_ready, overflow, result, exp_neg);
      end
    end
    @(negedge clock);
    res_ready = 1'b1;
    offer(2'b00, fill(8'd3), fill(8'd4));
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_busy: busy=%b vld=%b, required busy=1 vld=0", busy, res_valid);
    end
    wait_done(ok);
    n_cmp++;
    if (!ok || result !== fill(8'd7) || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_result: done=%b res=%h ovf=%b, required done=1 res=%h ovf=0",
               ok, result, overflow, fill(8'd7));
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    offer(2'b00, fill(8'd100), fill(8'd100));
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    // At this point, row 2 is in progress and the row-0 overflow is already recorded.
    n_cmp++;
    if (busy !== 1'b1 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre_reset: busy=%b ovf=%b, required busy=1 ovf=1", busy, overflow);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || overflow !== 1'b0 ||
        result !== '0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: busy=%b vld=%b ovf=%b rdy=%b res=%h, required busy=0 vld=0 ovf=0 rdy=1 res=0",
               busy, res_valid, overflow, cmd_ready, result);
    end
    offer(2'b00, fill(8'd1), fill(8'd2));
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    wait_done(ok);
    n_cmp++;
    if (!ok || result !== fill(8'd3) || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_add: done=%b res=%h ovf=%b, required done=1 res=%h ovf=0",
               ok, result, overflow, fill(8'd3));
    end
    release_result();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    opcode    = 2'b00;
    matrix_a  = '0;
    matrix_b  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_sub();
    test_add();
    test_transpose();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mpu_op_sequencer.md
Name: mpu_op_sequencer

Overview:
Multi-cycle controller and datapath for element-wise operations on 5x5 8-bit matrices in the MPU.
- Accepts one command (opcode plus two operand matrices) through a valid/ready handshake.
- Latches the operands and processes one row per cycle through a shared 5-lane 8-bit ALU.
- Presents the finished matrix through a second valid/ready handshake.
- Sits between the MPU command front-end and the result writeback path.

Parameters:
ELEM_W, 8, bit width of one matrix element
DIM, 5, matrix dimension; the matrix is DIM x DIM, the bus is ELEM_W*DIM*DIM bits

Ports:
clock  input  1  single clock; every register updates on the rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command can be accepted this cycle
opcode  input  2  00 add, 01 sub (a-b), 10 negate a, 11 transpose a
matrix_a  input  200  operand A, flattened
matrix_b  input  200  operand B, flattened; ignored for opcodes 10 and 11
res_valid  output  1  result matrix is complete and stable
res_ready  input  1  consumer accepts the result
result  output  200  result matrix, flattened
overflow  output  1  at least one element overflowed (signed) in the current result
busy  output  1  high in RUN

Behaviour:
- Element layout: element (row i, col j) occupies bits [8*(i+5*j) +: 8] on every matrix bus.
- States: IDLE, RUN, DONE. Row counter row[2:0] runs 0..4.
- Reset (synchronous, any state including mid-RUN):
  - state returns to IDLE; row is cleared to 0.
  - result, overflow, res_valid and busy are cleared to 0; the command in flight is discarded.
- cmd_ready is 1 in IDLE, and also in DONE when res_ready=1; it is 0 otherwise.
- Command accept (cmd_valid && cmd_ready at an edge):
  - latch opcode, matrix_a and matrix_b; clear overflow; set row=0; go to RUN.
- RUN, each edge:
  - write result row r = row, i.e. elements (r,0..4); OR the lane overflow flags into overflow.
  - if row==4, go to DONE; otherwise row increments.
  - Exactly 5 RUN cycles; res_valid rises at the 5th edge after the accept edge.
- Element arithmetic (per 8-bit element, independent lanes, no carry or borrow between elements):
  - add: a+b.
  - sub: a-b.
  - negate: 0-a.
  - transpose: result(r,j) = a(j,r); never sets overflow.
  - Without saturation, results wrap modulo 256.
  - Signed overflow is detected for add, sub and negate (negate overflows only for a = -128).
- DONE:
  - res_valid=1; result and overflow are held stable.
  - res_ready=1 with no new command: go to IDLE; res_valid drops on the next cycle.
  - res_ready=1 with cmd_valid=1 in the same cycle: the result is consumed, the new command is latched, and the state goes straight to RUN (back-to-back, no IDLE bubble).
  - res_ready=0: stay in DONE indefinitely; cmd_ready=0.
- Inputs are don't-care outside accept cycles; changes to matrix_a/b during RUN have no effect.
- During RUN, result holds a mix of new and old rows; it is valid only while res_valid=1.

Optional Feature:
MPU_SAT_EN
- Defined: add, sub and negate clamp each element to the signed range [-128, 127] on overflow.
  - Example: 100+100 gives 127; -128-1 gives -128; negating -128 gives 127.
  - overflow still reports that clamping occurred.
- Undefined: wrap-around modulo 256; overflow is still reported.
- Transpose is identical in both builds.

Test Plan:
- Reset, then idle: cmd_ready=1, res_valid=0, result=0, overflow=0, busy=0.
- Sub, all a elements = 1, all b elements = 25, one-cycle cmd_valid:
  - busy high for 5 cycles; res_valid rises 5 edges after the accept edge.
  - every element = 8'd232 (wrap build) with overflow=0.
- Add, all elements a = b = 100:
  - wrap build: every element 8'd200, overflow=1.
  - MPU_SAT_EN build: every element 8'd127, overflow=1.
- Transpose, a element (i,j) = 5*i+j:
  - result element (i,j) = 5*j+i; element (0,1) = 5, element (1,0) = 1; overflow=0.
- Backpressure and back-to-back:
  - Hold res_ready=0 for 10 cycles in DONE: result stable, cmd_ready=0.
  - Then assert res_ready and cmd_valid together: the next command is accepted that cycle and busy=1 on the next cycle.
- Reset asserted while row=2 in RUN:
  - next cycle is IDLE with all outputs 0.
  - a following add of all 1s + all 2s gives all elements 3.
